cache_ctrl_pf: RTL and testbench

//  Control FSM for a WAYS-way set-associative write-back cache with a next-N-line prefetcher.

---
 rtl/cache_ctrl_pf_if.sv | 21 ++
 rtl/cache_ctrl_pf.sv | 238 +++++++++++++++++++++++
 tb/tb_cache_ctrl_pf.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pf_if.sv
// CPU and pmem handshake bundle for the prefetching cache controller.
// master is the controller side; slave is the CPU/pmem side.
interface cache_ctrl_pf_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;
  logic pmem_wb_o;

  modport master (
    input  mem_read, mem_write, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_wb_o
  );

  modport slave (
    output mem_read, mem_write, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_wb_o
  );
endinterface

// File: rtl/cache_ctrl_pf.sv
// Control FSM for a set-associative write-back cache with a next-N-line prefetcher.
// Demand hits keep being served while a prefetch line read is outstanding.
module cache_ctrl_pf #(
  parameter int WAYS     = 4,
  parameter int PF_DEPTH = 2,
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int PW = (PF_DEPTH > 0) ? $clog2(PF_DEPTH + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_ctrl_pf_if.master      bus,
  input  logic                 hit,
  input  logic [WW-1:0]        hit_way,
  input  logic                 set_match_i,
  input  logic [WW-1:0]        victim_way,
  input  logic                 victim_dirty,
  input  logic                 pf_en_i,
  input  logic                 pf_boundary_i,
  output logic                 use_pf_addr_o,
  output logic [PW-1:0]        pf_offset_o,
  output logic [WW-1:0]        way_sel,
  output logic                 tag_load,
  output logic                 valid_load,
  output logic                 dirty_load,
  output logic                 dirty_in,
  output logic                 lru_load,
  output logic [1:0]           writing,
  output logic                 fetch_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WB        = 3'd1,
    ST_FILL      = 3'd2,
    ST_PF_CHECK  = 3'd3,
    ST_PF_WB     = 3'd4,
    ST_PF_FILL   = 3'd5,
    ST_PF_COMMIT = 3'd6
  } state_t;

  localparam logic [PW-1:0] PF_LAST = PW'(PF_DEPTH);
  localparam logic [PW-1:0] PF_ONE  = PW'(1);
  localparam bit            PF_ON   = (PF_DEPTH != 0);

  state_t          state_r;
  state_t          next_state_s;
  logic [WW-1:0]   dmd_way_r;
  logic [WW-1:0]   pf_way_r;
  logic [PW-1:0]   pf_cnt_r;
  logic            pf_pending_r;
  logic            miss_seen_r;

  logic            req_s;
  logic            resp_s;
  logic            adv_s;
  logic            dmd_latch_s;
  logic            pf_latch_s;
  logic            fill_done_s;
  logic            pend_clr_s;
  logic            pf_stop_s;
  logic            miss_mark_s;
  logic            mem_resp_s;
  logic            pmem_read_s;
  logic            pmem_write_s;
  logic            pmem_wb_s;

  assign req_s         = bus.mem_read | bus.mem_write;
  assign bus.mem_resp  = mem_resp_s;
  assign bus.pmem_read = pmem_read_s;
  assign bus.pmem_write = pmem_write_s;
  assign bus.pmem_wb_o = pmem_wb_s;
  assign pf_offset_o   = pf_cnt_r;

  // Next-state, output strobes and register-update requests.
  always_comb begin
    next_state_s  = state_r;
    mem_resp_s    = 1'b0;
    pmem_read_s   = 1'b0;
    pmem_write_s  = 1'b0;
    pmem_wb_s     = 1'b0;
    use_pf_addr_o = 1'b0;
    way_sel       = '0;
    tag_load      = 1'b0;
    valid_load    = 1'b0;
    dirty_load    = 1'b0;
    dirty_in      = 1'b0;
    lru_load      = 1'b0;
    writing       = 2'b11;
    fetch_o       = 1'b0;
    resp_s        = 1'b0;
    adv_s         = 1'b0;
    dmd_latch_s   = 1'b0;
    pf_latch_s    = 1'b0;
    fill_done_s   = 1'b0;
    pend_clr_s    = 1'b0;
    pf_stop_s     = 1'b0;
    miss_mark_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        resp_s = req_s & hit;
        // A demand miss pre-empts any pending prefetch chain.
        if (req_s && !hit) begin
          dmd_latch_s  = 1'b1;
          pend_clr_s   = 1'b1;
          next_state_s = victim_dirty ? ST_WB : ST_FILL;
        end else if (pf_pending_r) begin
          next_state_s = ST_PF_CHECK;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WB: begin
        pmem_write_s = 1'b1;
        pmem_wb_s    = 1'b1;
        way_sel      = dmd_way_r;
        next_state_s = bus.pmem_resp ? ST_FILL : ST_WB;
      end
      ST_FILL: begin
        pmem_read_s = 1'b1;
        writing     = 2'b00;
        way_sel     = dmd_way_r;
        if (bus.pmem_resp) begin
          tag_load     = 1'b1;
          valid_load   = 1'b1;
          dirty_load   = 1'b1;
          lru_load     = 1'b1;
          fetch_o      = 1'b1;
          fill_done_s  = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_FILL;
        end
      end
      ST_PF_CHECK: begin
        use_pf_addr_o = 1'b1;
        if (pf_boundary_i) begin
          pf_stop_s    = 1'b1;
          next_state_s = ST_IDLE;
        end else if (hit) begin
          adv_s = 1'b1;
        end else begin
          pf_latch_s   = 1'b1;
          next_state_s = victim_dirty ? ST_PF_WB : ST_PF_FILL;
        end
      end
      ST_PF_WB: begin
        use_pf_addr_o = 1'b1;
        pmem_write_s  = 1'b1;
        pmem_wb_s     = 1'b1;
        way_sel       = pf_way_r;
        next_state_s  = bus.pmem_resp ? ST_PF_FILL : ST_PF_WB;
      end
      ST_PF_FILL: begin
        pmem_read_s = 1'b1;
        // The way being refilled cannot answer a demand hit until its new tag lands.
        resp_s      = req_s & hit & ~(set_match_i & (hit_way == pf_way_r));
        miss_mark_s = req_s & ~hit;
        next_state_s = bus.pmem_resp ? ST_PF_COMMIT : ST_PF_FILL;
      end
      ST_PF_COMMIT: begin
        use_pf_addr_o = 1'b1;
        way_sel       = pf_way_r;
        writing       = 2'b00;
        tag_load      = 1'b1;
        valid_load    = 1'b1;
        dirty_load    = 1'b1;
        adv_s         = 1'b1;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase

    if (adv_s) begin
      if ((pf_cnt_r == PF_LAST) || miss_seen_r) begin
        pf_stop_s    = 1'b1;
        next_state_s = ST_IDLE;
      end else begin
        next_state_s = ST_PF_CHECK;
      end
    end else begin
      pf_stop_s = pf_stop_s;
    end

    if (resp_s) begin
      mem_resp_s = 1'b1;
      lru_load   = 1'b1;
      way_sel    = hit_way;
      if (bus.mem_write) begin
        dirty_load = 1'b1;
        dirty_in   = 1'b1;
        writing    = 2'b01;
      end else begin
        writing    = writing;
      end
    end else begin
      mem_resp_s = 1'b0;
    end
  end

  // State register plus latched ways and prefetch bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      dmd_way_r    <= '0;
      pf_way_r     <= '0;
      pf_cnt_r     <= '0;
      pf_pending_r <= 1'b0;
      miss_seen_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (dmd_latch_s) begin
        dmd_way_r <= victim_way;
      end
      if (pf_latch_s) begin
        pf_way_r <= victim_way;
      end
      if (fill_done_s) begin
        pf_pending_r <= pf_en_i & PF_ON;
      end else if (pend_clr_s || pf_stop_s) begin
        pf_pending_r <= 1'b0;
      end
      // The offset is held when the chain ends so it never exceeds PF_DEPTH.
      if (fill_done_s) begin
        pf_cnt_r <= PF_ONE;
      end else if (adv_s && !pf_stop_s) begin
        pf_cnt_r <= pf_cnt_r + PF_ONE;
      end
      if (pf_stop_s) begin
        miss_seen_r <= 1'b0;
      end else if (miss_mark_s) begin
        miss_seen_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_ctrl_pf.sv
// Directed testbench for cache_ctrl_pf (WAYS=4, PF_DEPTH=2).
module tb_cache_ctrl_pf;
  logic       clk;
  logic       rst;
  logic       hit;
  logic [1:0] hit_way;
  logic       set_match_i;
  logic [1:0] victim_way;
  logic       victim_dirty;
  logic       pf_en_i;
  logic       pf_boundary_i;
  logic       use_pf_addr_o;
  logic [1:0] pf_offset_o;
  logic [1:0] way_sel;
  logic       tag_load;
  logic       valid_load;
  logic       dirty_load;
  logic       dirty_in;
  logic       lru_load;
  logic [1:0] writing;
  logic       fetch_o;

  int checks;
  int errors;

  cache_ctrl_pf_if bus ();

  cache_ctrl_pf #(.WAYS(4), .PF_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .hit           (hit),
    .hit_way       (hit_way),
    .set_match_i   (set_match_i),
    .victim_way    (victim_way),
    .victim_dirty  (victim_dirty),
    .pf_en_i       (pf_en_i),
    .pf_boundary_i (pf_boundary_i),
    .use_pf_addr_o (use_pf_addr_o),
    .pf_offset_o   (pf_offset_o),
    .way_sel       (way_sel),
    .tag_load      (tag_load),
    .valid_load    (valid_load),
    .dirty_load    (dirty_load),
    .dirty_in      (dirty_in),
    .lru_load      (lru_load),
    .writing       (writing),
    .fetch_o       (fetch_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Invariants sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check_val("rw_overlap", 32'(bus.pmem_read & bus.pmem_write), 32'd0);
      check_val("pf_off_max", 32'(pf_offset_o <= 2'd2), 32'd1);
    end
  end

  // Demand miss with clean victim, immediate fill, then the demand hit in IDLE.
  task automatic do_fill(input logic [1:0] way, input logic pf);
    bus.mem_read = 1'b1; hit = 1'b0; victim_way = way; victim_dirty = 1'b0; pf_en_i = pf;
    settle();
    check_val("df_miss_noresp", 32'(bus.mem_resp), 32'd0);
    tick();
    bus.pmem_resp = 1'b1;
    settle();
    check_val("df_fill_read", 32'(bus.pmem_read), 32'd1);
    check_val("df_fetch", 32'(fetch_o), 32'd1);
    check_val("df_way", 32'(way_sel), 32'(way));
    tick();
    bus.pmem_resp = 1'b0; hit = 1'b1; hit_way = way;
    settle();
    check_val("df_hit_resp", 32'(bus.mem_resp), 32'd1);
    tick();
    bus.mem_read = 1'b0; hit = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0;
    hit = 1'b0; hit_way = 2'd0; set_match_i = 1'b0; victim_way = 2'd0;
    victim_dirty = 1'b0; pf_en_i = 1'b0; pf_boundary_i = 1'b0;
    tick(); tick();
    settle();
    check_val("rst_resp", 32'(bus.mem_resp), 32'd0);
    check_val("rst_pread", 32'(bus.pmem_read), 32'd0);
    check_val("rst_pwrite", 32'(bus.pmem_write), 32'd0);
    check_val("rst_writing", 32'(writing), 32'd3);
    check_val("rst_pfoff", 32'(pf_offset_o), 32'd0);
    rst = 1'b0;
    tick();

    // 1: cold read miss, clean victim, pmem_resp on the fifth FILL cycle
    bus.mem_read = 1'b1; victim_way = 2'd1;
    settle();
    check_val("t1_idle_noread", 32'(bus.pmem_read), 32'd0);
    tick();
    victim_way = 2'd3;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_val("t1_fill_read", 32'(bus.pmem_read), 32'd1);
      check_val("t1_fill_way", 32'(way_sel), 32'd1);
      check_val("t1_fill_nofetch", 32'(fetch_o), 32'd0);
      tick();
    end
    bus.pmem_resp = 1'b1;
    settle();
    check_val("t1_fetch", 32'(fetch_o), 32'd1);
    check_val("t1_tag", 32'(tag_load), 32'd1);
    check_val("t1_lru", 32'(lru_load), 32'd1);
    check_val("t1_dirty_in", 32'(dirty_in), 32'd0);
    check_val("t1_writing", 32'(writing), 32'd0);
    check_val("t1_noresp", 32'(bus.mem_resp), 32'd0);
    tick();
    bus.pmem_resp = 1'b0; hit = 1'b1; hit_way = 2'd1;
    settle();
    check_val("t1_resp", 32'(bus.mem_resp), 32'd1);
    check_val("t1_read_drop", 32'(bus.pmem_read), 32'd0);
    tick();
    bus.mem_read = 1'b0; hit = 1'b0;
    settle();
    check_val("t1_idle_nopf", 32'(use_pf_addr_o), 32'd0);
    tick();

    // 2: write hit on way 2
    bus.mem_write = 1'b1; hit = 1'b1; hit_way = 2'd2;
    settle();
    check_val("t2_resp", 32'(bus.mem_resp), 32'd1);
    check_val("t2_dload", 32'(dirty_load), 32'd1);
    check_val("t2_din", 32'(dirty_in), 32'd1);
    check_val("t2_writing", 32'(writing), 32'd1);
    check_val("t2_way", 32'(way_sel), 32'd2);
    check_val("t2_lru", 32'(lru_load), 32'd1);
    tick();
    bus.mem_write = 1'b0; hit = 1'b0;
    tick();

    // 3: dirty-victim miss: writeback then fill
    bus.mem_read = 1'b1; victim_way = 2'd3; victim_dirty = 1'b1;
    settle();
    check_val("t3_noresp", 32'(bus.mem_resp), 32'd0);
    tick();
    victim_way = 2'd0; victim_dirty = 1'b0;
    settle();
    check_val("t3_wb_write", 32'(bus.pmem_write), 32'd1);
    check_val("t3_wb_addr", 32'(bus.pmem_wb_o), 32'd1);
    check_val("t3_wb_noread", 32'(bus.pmem_read), 32'd0);
    check_val("t3_wb_way", 32'(way_sel), 32'd3);
    tick();
    bus.pmem_resp = 1'b1;
    settle();
    check_val("t3_wb_hold", 32'(bus.pmem_write), 32'd1);
    tick();
    bus.pmem_resp = 1'b0;
    settle();
    check_val("t3_fill_read", 32'(bus.pmem_read), 32'd1);
    check_val("t3_fill_nowrite", 32'(bus.pmem_write), 32'd0);
    check_val("t3_fill_nowb", 32'(bus.pmem_wb_o), 32'd0);
    check_val("t3_fill_way", 32'(way_sel), 32'd3);
    tick();
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0; hit = 1'b1; hit_way = 2'd3;
    settle();
    check_val("t3_resp", 32'(bus.mem_resp), 32'd1);
    tick();
    bus.mem_read = 1'b0; hit = 1'b0;
    tick();

    // 4a: prefetch chain, both lines absent
    do_fill(2'd0, 1'b1);
    victim_way = 2'd2;
    settle();
    check_val("t4_chk_pfaddr", 32'(use_pf_addr_o), 32'd1);
    check_val("t4_chk_off1", 32'(pf_offset_o), 32'd1);
    check_val("t4_chk_noread", 32'(bus.pmem_read), 32'd0);
    tick();
    bus.pmem_resp = 1'b1;
    settle();
    check_val("t4_pff1_read", 32'(bus.pmem_read), 32'd1);
    check_val("t4_pff1_off", 32'(pf_offset_o), 32'd1);
    check_val("t4_pff1_dmdaddr", 32'(use_pf_addr_o), 32'd0);
    tick();
    bus.pmem_resp = 1'b0;
    settle();
    check_val("t4_com1_tag", 32'(tag_load), 32'd1);
    check_val("t4_com1_way", 32'(way_sel), 32'd2);
    check_val("t4_com1_writing", 32'(writing), 32'd0);
    check_val("t4_com1_nolru", 32'(lru_load), 32'd0);
    check_val("t4_com1_pfaddr", 32'(use_pf_addr_o), 32'd1);
    tick();
    victim_way = 2'd3;
    settle();
    check_val("t4_chk2_off", 32'(pf_offset_o), 32'd2);
    tick();
    bus.pmem_resp = 1'b1;
    settle();
    check_val("t4_pff2_read", 32'(bus.pmem_read), 32'd1);
    check_val("t4_pff2_off", 32'(pf_offset_o), 32'd2);
    tick();
    bus.pmem_resp = 1'b0;
    settle();
    check_val("t4_com2_way", 32'(way_sel), 32'd3);
    tick();
    settle();
    check_val("t4_end_nopf", 32'(use_pf_addr_o), 32'd0);
    check_val("t4_end_noread", 32'(bus.pmem_read), 32'd0);
    tick();
    settle();
    check_val("t4_end_idle", 32'(use_pf_addr_o), 32'd0);
    tick();

    // 4b: line +1 present, single fill at offset 2
    do_fill(2'd1, 1'b1);
    hit = 1'b1;
    settle();
    check_val("t4b_chk1_off", 32'(pf_offset_o), 32'd1);
    check_val("t4b_chk1_noread", 32'(bus.pmem_read), 32'd0);
    tick();
    hit = 1'b0; victim_way = 2'd1;
    settle();
    check_val("t4b_chk2_pfaddr", 32'(use_pf_addr_o), 32'd1);
    check_val("t4b_chk2_off", 32'(pf_offset_o), 32'd2);
    tick();
    bus.pmem_resp = 1'b1;
    settle();
    check_val("t4b_pff_read", 32'(bus.pmem_read), 32'd1);
    check_val("t4b_pff_off", 32'(pf_offset_o), 32'd2);
    tick();
    bus.pmem_resp = 1'b0;
    settle();
    check_val("t4b_com_way", 32'(way_sel), 32'd1);
    tick();
    settle();
    check_val("t4b_end_nopf", 32'(use_pf_addr_o), 32'd0);
    tick();

    // 5: demand hits during PF_FILL, then a stalled same-way hit; boundary ends chain
    do_fill(2'd0, 1'b1);
    victim_way = 2'd2;
    tick();
    bus.mem_read = 1'b1; hit = 1'b1; hit_way = 2'd1; set_match_i = 1'b1;
    settle();
    check_val("t5_hit_resp", 32'(bus.mem_resp), 32'd1);
    check_val("t5_hit_read", 32'(bus.pmem_read), 32'd1);
    check_val("t5_hit_way", 32'(way_sel), 32'd1);
    tick();
    hit_way = 2'd2;
    settle();
    check_val("t5_stall", 32'(bus.mem_resp), 32'd0);
    tick();
    bus.pmem_resp = 1'b1;
    settle();
    check_val("t5_stall_resp", 32'(bus.mem_resp), 32'd0);
    tick();
    bus.pmem_resp = 1'b0;
    settle();
    check_val("t5_com_noresp", 32'(bus.mem_resp), 32'd0);
    check_val("t5_com_tag", 32'(tag_load), 32'd1);
    tick();
    pf_boundary_i = 1'b1;
    settle();
    check_val("t6_bnd_pfaddr", 32'(use_pf_addr_o), 32'd1);
    check_val("t6_bnd_noread", 32'(bus.pmem_read), 32'd0);
    check_val("t6_bnd_nowrite", 32'(bus.pmem_write), 32'd0);
    check_val("t6_bnd_noresp", 32'(bus.mem_resp), 32'd0);
    tick();
    pf_boundary_i = 1'b0;
    settle();
    check_val("t5_late_resp", 32'(bus.mem_resp), 32'd1);
    check_val("t5_late_way", 32'(way_sel), 32'd2);
    tick();
    bus.mem_read = 1'b0; hit = 1'b0; set_match_i = 1'b0;
    settle();
    check_val("t6_bnd_cleared", 32'(use_pf_addr_o), 32'd0);
    tick();

    // 6: demand miss during PF_FILL aborts the chain after commit
    do_fill(2'd0, 1'b1);
    victim_way = 2'd3;
    tick();
    bus.mem_read = 1'b1; hit = 1'b0;
    settle();
    check_val("t6_miss_noresp", 32'(bus.mem_resp), 32'd0);
    tick();
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
    settle();
    check_val("t6_com_tag", 32'(tag_load), 32'd1);
    check_val("t6_com_way", 32'(way_sel), 32'd3);
    tick();
    victim_way = 2'd1; pf_en_i = 1'b0;
    settle();
    check_val("t6_abort_nopf", 32'(use_pf_addr_o), 32'd0);
    check_val("t6_abort_noresp", 32'(bus.mem_resp), 32'd0);
    tick();
    bus.pmem_resp = 1'b1;
    settle();
    check_val("t6_dmd_fill", 32'(bus.pmem_read), 32'd1);
    check_val("t6_dmd_way", 32'(way_sel), 32'd1);
    check_val("t6_dmd_dmdaddr", 32'(use_pf_addr_o), 32'd0);
    tick();
    bus.pmem_resp = 1'b0; hit = 1'b1; hit_way = 2'd1;
    settle();
    check_val("t6_dmd_resp", 32'(bus.mem_resp), 32'd1);
    tick();
    bus.mem_read = 1'b0; hit = 1'b0;
    tick();

    // 6c: reset in the middle of a writeback
    bus.mem_read = 1'b1; victim_way = 2'd2; victim_dirty = 1'b1;
    tick();
    settle();
    check_val("t6_rst_wb", 32'(bus.pmem_write), 32'd1);
    rst = 1'b1; bus.mem_read = 1'b0; victim_dirty = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    check_val("t6_rst_nowrite", 32'(bus.pmem_write), 32'd0);
    check_val("t6_rst_noread", 32'(bus.pmem_read), 32'd0);
    check_val("t6_rst_writing", 32'(writing), 32'd3);
    tick();
    settle();
    check_val("t6_rst_stays", 32'(bus.pmem_write), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
